// File: rtl/jt12_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jt12_pkg
// Purpose : Shared definitions for the channel register bank: write-select
//           encodings, the packed {block, fnum} record and the legal
//           channel-count check.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package jt12_pkg;

  // Register-select codes carried on wr_sel.
  typedef enum logic [2:0] {
    SEL_FNUM_HI    = 3'd0,  // latch block + fnum[10:8]
    SEL_FNUM_LO    = 3'd1,  // commit {hi latch, fnum[7:0]}
    SEL_FB_ALG     = 3'd2,
    SEL_RL_AMS_PMS = 3'd3,
    SEL_SP_HI      = 3'd4,  // special-slot hi latch
    SEL_SP_LO      = 3'd5,  // special-slot commit
    SEL_RSV6       = 3'd6,
    SEL_RSV7       = 3'd7
  } wr_sel_e;

  // Frequency word as stored: 3-bit block over 11-bit fnum.
  typedef struct packed {
    logic [2:0]  blk;
    logic [10:0] fnum;
  } fnum_t;

  localparam int c_NUM_SP_SLOTS = 3;

  // Channel counts the bank supports.
  function automatic logic num_ch_legal(input int n);
    return (n == 3) || (n == 6) || (n == 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jt12_chreg_fnum.sv
`default_nettype none
// ============================================================================
// Module  : jt12_chreg_fnum
// Purpose : Two-step frequency write: a hi latch (block + fnum[10:8]) with a
//           pending flag, committed together with the lo byte into one of
//           NSLOT stored words. One hi latch is shared by all slots.
// Ports   : clk, rst (async, active-high)
//           i_hi_we  - capture i_din[5:0] into the hi latch, set pending
//           i_lo_we  - store {hi latch, i_din} into slot i_slot, clear pending
//           i_slot   - target slot for i_lo_we
//           i_din    - write data
//           o_val    - stored {block, fnum} per slot
//           o_pend   - hi latched, commit not yet done
// Revision: 1.0 - initial release
// ============================================================================
module jt12_chreg_fnum
  import jt12_pkg::*;
#(
  parameter int NSLOT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_hi_we,
  input  logic                  i_lo_we,
  input  logic [1:0]            i_slot,
  input  logic [7:0]            i_din,
  output fnum_t [NSLOT-1:0]     o_val,
  output logic                  o_pend
);

  logic [5:0]          r_hi;
  logic                r_pend;
  fnum_t [NSLOT-1:0]   r_val;

  // The hi latch keeps its value after a commit, so a lo write without a
  // fresh hi write reuses the last hi byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi   <= 6'd0;
      r_pend <= 1'b0;
    end else if (i_hi_we) begin
      r_hi   <= i_din[5:0];
      r_pend <= 1'b1;
    end else if (i_lo_we) begin
      r_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val <= '0;
    end else if (i_lo_we) begin
      for (int s = 0; s < NSLOT; s++) begin
        if (i_slot == 2'(s)) begin
          r_val[s] <= {r_hi, i_din};
        end
      end
    end
  end

  assign o_val  = r_val;
  assign o_pend = r_pend;

endmodule
`default_nettype wire

// File: rtl/jt12_chreg_bank.sv
`default_nettype none
// ============================================================================
// Module  : jt12_chreg_bank
// Purpose : Per-channel FM parameter registers (block/fnum, fb/alg,
//           rl/ams/pms) with a cen-gated registered read port and optional
//           per-operator fnum slots for channel index 2.
// Ports   : rst (async, active-high), clk, cen (read pipeline enable)
//           din, wr_en, wr_sel, wr_ch, wr_op - write port (independent of cen)
//           ch, op, ch3_mode                 - read selection
//           block, fnum, fb, alg, rl, ams, pms - registered read data
//           hi_pend                           - per-channel hi-pending flags
// Revision: 1.0 - initial release
// ============================================================================
module jt12_chreg_bank
  import jt12_pkg::*;
#(
  parameter int NUM_CH      = 6,
  parameter int AMS_SKEW    = 3,
  parameter int CH3_SPECIAL = 1
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              cen,
  input  logic [7:0]        din,
  input  logic              wr_en,
  input  logic [2:0]        wr_sel,
  input  logic [2:0]        wr_ch,
  input  logic [1:0]        wr_op,
  input  logic [2:0]        ch,
  input  logic [1:0]        op,
  input  logic              ch3_mode,
  output logic [2:0]        block,
  output logic [10:0]       fnum,
  output logic [2:0]        fb,
  output logic [2:0]        alg,
  output logic [1:0]        rl,
  output logic [1:0]        ams,
  output logic [2:0]        pms,
  output logic [NUM_CH-1:0] hi_pend
);

  if (!num_ch_legal(NUM_CH)) begin : g_bad_num_ch
    $error("jt12_chreg_bank: NUM_CH must be 3, 6 or 8");
  end

  localparam int         c_SKEW    = AMS_SKEW % NUM_CH;
  localparam logic [3:0] c_NUM_CH  = 4'(NUM_CH);
  localparam logic [3:0] c_AMS_ADD = 4'(NUM_CH - c_SKEW);

  // ---------------------------------------------------------------- writes
  wr_sel_e w_sel;
  logic    w_wr_ok;
  logic    w_sp_ok;

  assign w_sel   = wr_sel_e'(wr_sel);
  assign w_wr_ok = wr_en && ({1'b0, wr_ch} < c_NUM_CH);
  assign w_sp_ok = w_wr_ok && (CH3_SPECIAL != 0) && (wr_op != 2'd3);

  logic [2:0] r_ch_fb  [NUM_CH];
  logic [2:0] r_ch_alg [NUM_CH];
  logic [1:0] r_ch_rl  [NUM_CH];
  logic [1:0] r_ch_ams [NUM_CH];
  logic [2:0] r_ch_pms [NUM_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_ch_fb[i]  <= 3'd0;
        r_ch_alg[i] <= 3'd0;
        r_ch_rl[i]  <= 2'd3;
        r_ch_ams[i] <= 2'd0;
        r_ch_pms[i] <= 3'd0;
      end
    end else if (w_wr_ok) begin
      case (w_sel)
        SEL_FB_ALG: begin
          r_ch_fb[wr_ch]  <= din[5:3];
          r_ch_alg[wr_ch] <= din[2:0];
        end
        SEL_RL_AMS_PMS: begin
          r_ch_rl[wr_ch]  <= din[7:6];
          r_ch_ams[wr_ch] <= din[5:4];
          r_ch_pms[wr_ch] <= din[2:0];
        end
        default: ;
      endcase
    end
  end

  fnum_t [NUM_CH-1:0] w_ch_val;
  logic  [NUM_CH-1:0] w_ch_pend;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    jt12_chreg_fnum #(.NSLOT(1)) u_fnum (
      .clk     (clk),
      .rst     (rst),
      .i_hi_we (w_wr_ok && (w_sel == SEL_FNUM_HI) && (wr_ch == 3'(c))),
      .i_lo_we (w_wr_ok && (w_sel == SEL_FNUM_LO) && (wr_ch == 3'(c))),
      .i_slot  (2'd0),
      .i_din   (din),
      .o_val   (w_ch_val[c]),
      .o_pend  (w_ch_pend[c])
    );
  end

  fnum_t [c_NUM_SP_SLOTS-1:0] w_sp_val;
  logic                       w_sp_pend;

  if (CH3_SPECIAL != 0) begin : g_special
    jt12_chreg_fnum #(.NSLOT(c_NUM_SP_SLOTS)) u_sp_fnum (
      .clk     (clk),
      .rst     (rst),
      .i_hi_we (w_sp_ok && (w_sel == SEL_SP_HI)),
      .i_lo_we (w_sp_ok && (w_sel == SEL_SP_LO)),
      .i_slot  (wr_op),
      .i_din   (din),
      .o_val   (w_sp_val),
      .o_pend  (w_sp_pend)
    );
  end else begin : g_no_special
    assign w_sp_val  = '0;
    assign w_sp_pend = 1'b0;
  end

  assign hi_pend = w_ch_pend;

  // ----------------------------------------------------------------- reads
  logic       w_rd_valid;
  logic [2:0] w_rd_idx;
  logic [3:0] w_ams_sum;
  logic [2:0] w_ams_idx;
  logic       w_sp_sel;
  fnum_t      w_rd_fnum;

  assign w_rd_valid = ({1'b0, ch} < c_NUM_CH);
  assign w_rd_idx   = w_rd_valid ? ch : 3'd0;

  // (ch - skew) mod NUM_CH computed as ch + (NUM_CH - skew) with one wrap.
  assign w_ams_sum  = {1'b0, w_rd_idx} + c_AMS_ADD;
  assign w_ams_idx  = (w_ams_sum >= c_NUM_CH) ? 3'(w_ams_sum - c_NUM_CH)
                                              : w_ams_sum[2:0];

  assign w_sp_sel   = (CH3_SPECIAL != 0) && ch3_mode && (ch == 3'd2) &&
                      (op != 2'd3);
  assign w_rd_fnum  = w_sp_sel ? w_sp_val[op] : w_ch_val[w_rd_idx];

  logic [2:0]  r_block;
  logic [10:0] r_fnum;
  logic [2:0]  r_fb;
  logic [2:0]  r_alg;
  logic [1:0]  r_rl;
  logic [1:0]  r_ams;
  logic [2:0]  r_pms;

  // Non-blocking update samples the storage as it was before this edge, so
  // a same-edge write only shows up on the following cen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_block <= 3'd0;
      r_fnum  <= 11'd0;
      r_fb    <= 3'd0;
      r_alg   <= 3'd0;
      r_rl    <= 2'd3;
      r_ams   <= 2'd0;
      r_pms   <= 3'd0;
    end else if (cen) begin
      if (w_rd_valid) begin
        r_block <= w_rd_fnum.blk;
        r_fnum  <= w_rd_fnum.fnum;
        r_fb    <= r_ch_fb[w_rd_idx];
        r_alg   <= r_ch_alg[w_rd_idx];
        r_rl    <= (NUM_CH == 3) ? 2'd3 : r_ch_rl[w_rd_idx];
        r_ams   <= r_ch_ams[w_ams_idx];
        r_pms   <= r_ch_pms[w_rd_idx];
      end else begin
        r_block <= 3'd0;
        r_fnum  <= 11'd0;
        r_fb    <= 3'd0;
        r_alg   <= 3'd0;
        r_rl    <= (NUM_CH == 3) ? 2'd3 : 2'd0;
        r_ams   <= 2'd0;
        r_pms   <= 3'd0;
      end
    end
  end

  assign block = r_block;
  assign fnum  = r_fnum;
  assign fb    = r_fb;
  assign alg   = r_alg;
  assign rl    = r_rl;
  assign ams   = r_ams;
  assign pms   = r_pms;

endmodule
`default_nettype wire

// File: tb/tb_jt12_chreg_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_jt12_chreg_bank
// Purpose : Self-checking bench for jt12_chreg_bank (NUM_CH=6, AMS_SKEW=3,
//           CH3_SPECIAL=1): directed writes/reads against a behavioural
//           model, plus literal expectations for the key scenarios.
// Revision: 1.0 - initial release
// ============================================================================
module tb_jt12_chreg_bank;

  localparam int NCH  = 6;
  localparam int SKEW = 3;

  logic           clk = 1'b0;
  logic           rst, cen, wr_en, ch3_mode;
  logic [7:0]     din;
  logic [2:0]     wr_sel, wr_ch, ch;
  logic [1:0]     wr_op, op;
  logic [2:0]     block, fb, alg, pms;
  logic [10:0]    fnum;
  logic [1:0]     rl, ams;
  logic [NCH-1:0] hi_pend;

  always #5 clk = ~clk;

  jt12_chreg_bank #(.NUM_CH(NCH), .AMS_SKEW(SKEW), .CH3_SPECIAL(1)) dut (
    .rst(rst), .clk(clk), .cen(cen), .din(din), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_ch(wr_ch), .wr_op(wr_op), .ch(ch), .op(op),
    .ch3_mode(ch3_mode), .block(block), .fnum(fnum), .fb(fb), .alg(alg),
    .rl(rl), .ams(ams), .pms(pms), .hi_pend(hi_pend)
  );

  // ---------------------------------------------------------------- model
  // Frequency words kept as a single integer: hi6 * 256 + lo8.
  int m_bf[8], m_fb[8], m_alg[8], m_rl[8], m_ams[8], m_pms[8];
  int m_hi[8], m_pend[8];
  int m_sphi, m_sp[3];
  int e_block, e_fnum, e_fb, e_alg, e_rl, e_ams, e_pms;
  int n_pass, n_total;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_bf[i] = 0; m_fb[i] = 0; m_alg[i] = 0; m_rl[i] = 3;
      m_ams[i] = 0; m_pms[i] = 0; m_hi[i] = 0; m_pend[i] = 0;
    end
    m_sphi = 0;
    for (int i = 0; i < 3; i++) m_sp[i] = 0;
    e_block = 0; e_fnum = 0; e_fb = 0; e_alg = 0; e_rl = 3; e_ams = 0; e_pms = 0;
  endtask

  // One clock edge: outputs come from state before the edge, then the write.
  task automatic model_step();
    int c, v, w;
    c = int'(ch);
    w = int'(wr_ch);
    if (cen) begin
      if (c >= NCH) begin
        e_block = 0; e_fnum = 0; e_fb = 0; e_alg = 0; e_ams = 0; e_pms = 0;
        e_rl = (NCH == 3) ? 3 : 0;
      end else begin
        v = (ch3_mode && c == 2 && op < 3) ? m_sp[op] : m_bf[c];
        e_block = v / 2048;
        e_fnum  = v % 2048;
        e_fb    = m_fb[c];
        e_alg   = m_alg[c];
        e_rl    = (NCH == 3) ? 3 : m_rl[c];
        e_ams   = m_ams[((c - SKEW) % NCH + NCH) % NCH];
        e_pms   = m_pms[c];
      end
    end
    if (wr_en && w < NCH) begin
      case (int'(wr_sel))
        0: begin m_hi[w] = din % 64; m_pend[w] = 1; end
        1: begin m_bf[w] = m_hi[w] * 256 + din; m_pend[w] = 0; end
        2: begin m_fb[w] = (din / 8) % 8; m_alg[w] = din % 8; end
        3: begin m_rl[w] = din / 64; m_ams[w] = (din / 16) % 4; m_pms[w] = din % 8; end
        4: if (wr_op < 3) m_sphi = din % 64;
        5: if (wr_op < 3) m_sp[wr_op] = m_sphi * 256 + din;
        default: ;
      endcase
    end
  endtask

  function automatic logic [15:0] exp_pend();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i] = (m_pend[i] != 0);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, got, exp);
  endtask

  // Every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("block",   16'(block),   16'(e_block));
    chk("fnum",    16'(fnum),    16'(e_fnum));
    chk("fb",      16'(fb),      16'(e_fb));
    chk("alg",     16'(alg),     16'(e_alg));
    chk("rl",      16'(rl),      16'(e_rl));
    chk("ams",     16'(ams),     16'(e_ams));
    chk("pms",     16'(pms),     16'(e_pms));
    chk("hi_pend", 16'(hi_pend), exp_pend());
  end

  // ------------------------------------------------------------- stimulus
  task automatic cyc(input bit en, input int sel, input int wch, input int wop, input int d);
    @(negedge clk);
    wr_en = en; wr_sel = 3'(sel); wr_ch = 3'(wch); wr_op = 2'(wop); din = 8'(d);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst = 1'b1; wr_en = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; cen = 1'b1; wr_en = 1'b0; wr_sel = 3'd0; wr_ch = 3'd0;
    wr_op = 2'd0; din = 8'd0; ch = 3'd0; op = 2'd0; ch3_mode = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    chk("lit_rst_rl", 16'(rl), 16'd3);
    chk("lit_rst_fnum", 16'(fnum), 16'd0);
    chk("lit_rst_pend", 16'(hi_pend), 16'd0);

    // hi 0x22 / lo 0x34 to ch1
    cyc(1, 0, 1, 0, 'h22);
    chk("lit_pend1_set", 16'(hi_pend), 16'b000010);
    ch = 3'd1;
    cyc(1, 1, 1, 0, 'h34);
    chk("lit_pend1_clr", 16'(hi_pend), 16'd0);
    idle();
    chk("lit_ch1_block", 16'(block), 16'd4);
    chk("lit_ch1_fnum", 16'(fnum), 16'h234);

    // interleaved hi writes on ch0 and ch4
    ch = 3'd0;
    cyc(1, 0, 0, 0, 'h11);
    cyc(1, 0, 4, 0, 'h2A);
    chk("lit_pend_0_4", 16'(hi_pend), 16'b010001);
    cyc(1, 1, 0, 0, 'h01);
    cyc(1, 1, 4, 0, 'h02);
    idle();
    chk("lit_ch0_block", 16'(block), 16'd2);
    chk("lit_ch0_fnum", 16'(fnum), 16'h101);
    ch = 3'd4;
    idle();
    chk("lit_ch4_block", 16'(block), 16'd5);
    chk("lit_ch4_fnum", 16'(fnum), 16'h202);

    // special slot 1 vs channel 2
    cyc(1, 0, 2, 0, 'h0D);
    cyc(1, 1, 2, 0, 'h66);
    cyc(1, 4, 2, 1, 'h19);
    cyc(1, 5, 2, 1, 'hFF);
    ch = 3'd2; op = 2'd1; ch3_mode = 1'b1;
    idle();
    chk("lit_sp1_block", 16'(block), 16'd3);
    chk("lit_sp1_fnum", 16'(fnum), 16'h1FF);
    op = 2'd3;
    idle();
    chk("lit_op3_fnum", 16'(fnum), 16'h566);
    op = 2'd1; ch3_mode = 1'b0;
    idle();
    chk("lit_mode0_block", 16'(block), 16'd1);
    chk("lit_mode0_fnum", 16'(fnum), 16'h566);

    // wr_op=3 special writes are dropped, shared hi latch survives
    ch3_mode = 1'b1; op = 2'd0;
    cyc(1, 4, 2, 3, 'h3F);
    cyc(1, 5, 2, 3, 'h00);
    cyc(1, 5, 2, 0, 'h01);
    idle();
    chk("lit_sp0_block", 16'(block), 16'd3);
    chk("lit_sp0_fnum", 16'(fnum), 16'h101);

    // ams skew, out-of-range channel writes and reads, reserved selects
    ch3_mode = 1'b0;
    cyc(1, 3, 0, 0, 'h65);
    ch = 3'd3;
    idle();
    chk("lit_ams_skew", 16'(ams), 16'd2);
    ch = 3'd0;
    idle();
    chk("lit_ch0_rl", 16'(rl), 16'd1);
    chk("lit_ch0_pms", 16'(pms), 16'd5);
    cyc(1, 2, 7, 0, 'hFF);
    cyc(1, 0, 7, 0, 'h3F);
    cyc(1, 1, 7, 0, 'hFF);
    cyc(1, 3, 7, 0, 'hFF);
    cyc(1, 6, 0, 0, 'hFF);
    cyc(1, 7, 0, 0, 'hFF);
    ch = 3'd7;
    idle();
    chk("lit_ch7_rl", 16'(rl), 16'd0);
    chk("lit_ch7_fnum", 16'(fnum), 16'd0);
    ch = 3'd0;
    idle();
    chk("lit_ch0_rl_kept", 16'(rl), 16'd1);

    // read-before-write on the same edge
    ch = 3'd5;
    cyc(1, 2, 5, 0, 'h05);
    chk("lit_alg_old", 16'(alg), 16'd0);
    idle();
    chk("lit_alg_new", 16'(alg), 16'd5);

    // cen low holds outputs; writes still land
    cen = 1'b0; ch = 3'd1;
    cyc(1, 2, 1, 0, 'h3F);
    chk("lit_cen_hold", 16'(fnum), 16'd0);
    cen = 1'b1;
    idle();
    chk("lit_cen_alg", 16'(alg), 16'd7);
    chk("lit_cen_fnum", 16'(fnum), 16'h234);

    // pending hi discarded by reset
    cyc(1, 0, 3, 0, 'h3F);
    pulse_reset();
    chk("lit_prst_pend", 16'(hi_pend), 16'd0);
    ch = 3'd3;
    cyc(1, 1, 3, 0, 'h10);
    idle();
    chk("lit_prst_block", 16'(block), 16'd0);
    chk("lit_prst_fnum", 16'(fnum), 16'h010);
    for (int c = 0; c < NCH; c++) begin
      ch = 3'(c);
      idle();
      chk("lit_prst_rl", 16'(rl), 16'd3);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jt12_chreg_bank.md
JT12_CHREG_BANK -- requirements
Module: jt12_chreg_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, meaning channel count; legal values 3, 6, 8.
REQ-002 SHALL have parameter AMS_SKEW, default 3, meaning channel offset applied to the AMS read index; 0 disables the offset.
REQ-003 SHALL have parameter CH3_SPECIAL, default 1, meaning per-operator fnum storage for channel index 2 is present; 0 removes it.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clk  input  1  clock.
REQ-006 cen  input  1  clock enable; gates the read pipeline only.
REQ-007 din  input  8  write data.
REQ-008 wr_en  input  1  write strobe, one clk per access.
REQ-009 wr_sel  input  3  0=fnum-hi latch, 1=fnum-lo commit, 2=fb/alg, 3=rl/ams/pms, 4=special-hi latch, 5=special-lo commit; 6 and 7 are ignored.
REQ-010 wr_ch  input  3  target channel.
REQ-011 wr_op  input  2  special slot 0..2 for wr_sel 4 and 5.
REQ-012 ch  input  3  channel to read.
REQ-013 op  input  2  operator slot being read.
REQ-014 ch3_mode  input  1  special-fnum mode enable.
REQ-015 block, fnum, fb, alg, rl, ams, pms  output  3, 11, 3, 3, 2, 2, 3  registered channel parameters.
REQ-016 hi_pend  output  NUM_CH  per-channel flag: fnum-hi latch written, lo commit not yet done.

Function
REQ-017 Writes SHALL occur on any clk edge with wr_en high, independent of cen.
REQ-018 wr_sel=0 SHALL store din[5:0] in that channel's own hi latch and set hi_pend[wr_ch].
REQ-019 wr_sel=1 SHALL load {block, fnum} of wr_ch with {hi latch, din} in one step and clear hi_pend[wr_ch].
REQ-020 wr_sel=1 with hi_pend clear SHALL reuse the last latched hi value.
REQ-021 Hi latches SHALL be per channel, so interleaved hi writes to different channels do not corrupt each other.
REQ-022 wr_sel=2 SHALL store fb=din[5:3] and alg=din[2:0].
REQ-023 wr_sel=3 SHALL store rl=din[7:6], ams=din[5:4] and pms=din[2:0].
REQ-024 wr_sel=4 and 5 SHALL mirror the hi/lo semantics on the special slot wr_op, using a single shared special hi latch.
REQ-025 wr_sel 4 and 5 SHALL be ignored when CH3_SPECIAL=0 or wr_op=3.
REQ-026 Writes with wr_ch>=NUM_CH SHALL be ignored with no state change.
REQ-027 On each cen, outputs SHALL update from the state present before that edge (read-before-write), giving 1 cen cycle latency.
REQ-028 ams SHALL be read at index (ch-AMS_SKEW) mod NUM_CH; all other fields SHALL be read at index ch.
REQ-029 When ch3_mode=1, CH3_SPECIAL=1, ch=2 and op<3, block and fnum SHALL come from special slot op; otherwise they come from the channel registers.
REQ-030 A read with ch>=NUM_CH SHALL return all fields zero, with rl=0.
REQ-031 When NUM_CH=3, rl SHALL always output 3.

Reset
REQ-032 rst SHALL set every channel to rl=3 and all other fields to 0, and clear all hi latches, special slots and hi_pend.
REQ-033 rst SHALL set the outputs to block=0, fnum=0, fb=0, alg=0, rl=3, ams=0, pms=0.
REQ-034 A hi latch pending when rst asserts SHALL be discarded; a later lo commit after reset uses hi=0.

Structure
REQ-035 The wr_sel encodings and the legal NUM_CH set SHALL live in the shared package jt12_pkg.
REQ-036 A single sub-module, jt12_chreg_fnum (hi latch, pend flag and commit), SHALL be instantiated NUM_CH times and once more for the special slots.

Verification
REQ-037 Bench SHALL cover: hi=0x22 to ch1, lo=0x34 to ch1, then read ch=1 -> block=4, fnum=0x234, hi_pend[1] returns to 0.
REQ-038 Bench SHALL cover: hi to ch0 (0x11), hi to ch4 (0x2A), lo 0x01 to ch0, lo 0x02 to ch4 -> ch0 {2,0x101}, ch4 {5,0x202}.
REQ-039 Bench SHALL cover: ch3_mode=1, special slot1 set to 0x1FF/blk 3, read ch=2 op=1 -> {3,0x1FF}; read op=3 -> channel-2 value; with ch3_mode=0, op=1 -> channel-2 value.
REQ-040 Bench SHALL cover: NUM_CH=6, ams=2 written to ch0, read ch=3 -> ams=2; write to wr_ch=7 -> no state change, and read ch=7 -> all zero.
REQ-041 Bench SHALL cover: write alg=5 and read the same channel on the same edge -> old alg on that edge, 5 on the next cen.
REQ-042 Bench SHALL cover: hi write, then rst pulse, then lo=0x10 -> block=0, fnum=0x010; rl reads 3 on every channel.
